cache_miss_ctrl: RTL and testbench

CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

---
 rtl/cache_miss_ctrl.sv | 126 ++++++++++++
 tb/tb_cache_miss_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_ctrl.sv
// ============================================================================
// cache_miss_ctrl : miss handler (victim select, writeback, line refill, PLRU update)
// Revision 1.0
// ============================================================================
`default_nettype none

module cache_miss_ctrl #(
  parameter int ASSOC_NUM  = 4,
  parameter int LINE_WORDS = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          miss_valid,
  input  logic [ADDR_WIDTH-1:0]         miss_addr,
  output logic                          miss_ready,
  input  logic [ASSOC_NUM-1:0]          set_valid,
  input  logic [ASSOC_NUM-1:0]          set_dirty,
  input  logic [$clog2(ASSOC_NUM)-1:0]  victim_lru,
  output logic                          wb_req,
  output logic [$clog2(ASSOC_NUM)-1:0]  wb_way,
  input  logic                          wb_done,
  output logic                          rd_req,
  output logic [ADDR_WIDTH-1:0]         rd_addr,
  input  logic                          rd_ready,
  input  logic                          rd_valid,
  input  logic [DATA_WIDTH-1:0]         rd_data,
  input  logic                          rd_last,
  output logic                          refill_we,
  output logic [$clog2(ASSOC_NUM)-1:0]  refill_way,
  output logic [$clog2(LINE_WORDS)-1:0] refill_word,
  output logic [DATA_WIDTH-1:0]         refill_data,
  output logic [ASSOC_NUM-1:0]          repl_access,
  output logic                          repl_update,
  output logic                          refill_done
);

  localparam int c_way_w  = $clog2(ASSOC_NUM);
  localparam int c_word_w = $clog2(LINE_WORDS);
  localparam int c_off_w  = $clog2(LINE_WORDS * DATA_WIDTH / 8);

  localparam logic [2:0] c_s_idle    = 3'd0;
  localparam logic [2:0] c_s_select  = 3'd1;
  localparam logic [2:0] c_s_wb      = 3'd2;
  localparam logic [2:0] c_s_rd_req  = 3'd3;
  localparam logic [2:0] c_s_rd_data = 3'd4;
  localparam logic [2:0] c_s_done    = 3'd5;

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [c_way_w-1:0]    r_way;
  logic [c_word_w-1:0]   r_beat;

  logic [c_way_w-1:0]    w_victim;
  logic                  w_victim_dirty;
  logic [ADDR_WIDTH-1:0] w_line_mask;
  logic [ASSOC_NUM-1:0]  w_onehot;

  // Descending scan so the lowest-index invalid way is the last to win.
  always_comb begin
    w_victim = victim_lru;
    for (int i = ASSOC_NUM - 1; i >= 0; i--) begin
      if (!set_valid[i]) w_victim = c_way_w'(i);
    end
  end

  assign w_victim_dirty = set_valid[w_victim] & set_dirty[w_victim];
  assign w_line_mask    = {ADDR_WIDTH{1'b1}} << c_off_w;
  assign w_onehot       = {{(ASSOC_NUM-1){1'b0}}, 1'b1} << r_way;

  always_ff @(posedge clk) begin
    if (resetn) begin
      r_state <= c_s_idle;
      r_addr  <= '0;
      r_way   <= '0;
      r_beat  <= '0;
    end else begin
      case (r_state)
        c_s_idle: begin
          if (miss_valid) begin
            r_addr  <= miss_addr;
            r_state <= c_s_select;
          end
        end
        c_s_select: begin
          r_way   <= w_victim;
          r_state <= w_victim_dirty ? c_s_wb : c_s_rd_req;
        end
        c_s_wb: begin
          if (wb_done) r_state <= c_s_rd_req;
        end
        c_s_rd_req: begin
          if (rd_ready) begin
            r_beat  <= '0;
            r_state <= c_s_rd_data;
          end
        end
        c_s_rd_data: begin
          if (rd_valid) begin
            r_beat <= r_beat + c_word_w'(1);
            if (rd_last) r_state <= c_s_done;
          end
        end
        c_s_done: r_state <= c_s_idle;
        default:  r_state <= c_s_idle;
      endcase
    end
  end

  assign miss_ready  = (r_state == c_s_idle);
  assign wb_req      = (r_state == c_s_wb);
  assign wb_way      = r_way;
  assign rd_req      = (r_state == c_s_rd_req);
  assign rd_addr     = r_addr & w_line_mask;
  assign refill_we   = (r_state == c_s_rd_data) & rd_valid;
  assign refill_way  = r_way;
  assign refill_word = r_beat;
  assign refill_data = rd_data;
  assign refill_done = (r_state == c_s_done);
  assign repl_update = (r_state == c_s_done);
  assign repl_access = (r_state == c_s_done) ? w_onehot : '0;

endmodule

`default_nettype wire

// File: tb/tb_cache_miss_ctrl.sv
// ============================================================================
// tb_cache_miss_ctrl : scoreboard bench for cache_miss_ctrl (default parameters)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_cache_miss_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        miss_valid;
  logic [31:0] miss_addr;
  logic        miss_ready;
  logic [3:0]  set_valid;
  logic [3:0]  set_dirty;
  logic [1:0]  victim_lru;
  logic        wb_req;
  logic [1:0]  wb_way;
  logic        wb_done;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        refill_we;
  logic [1:0]  refill_way;
  logic [2:0]  refill_word;
  logic [31:0] refill_data;
  logic [3:0]  repl_access;
  logic        repl_update;
  logic        refill_done;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0]  way;
    logic [2:0]  word;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [3:0] done_q[$];
  wr_t        mon_e;
  logic [3:0] mon_a;

  cache_miss_ctrl #(
    .ASSOC_NUM(4), .LINE_WORDS(8), .ADDR_WIDTH(32), .DATA_WIDTH(32)
  ) dut (
    .clk(clk), .resetn(resetn),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .set_valid(set_valid), .set_dirty(set_dirty), .victim_lru(victim_lru),
    .wb_req(wb_req), .wb_way(wb_way), .wb_done(wb_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .refill_we(refill_we), .refill_way(refill_way), .refill_word(refill_word),
    .refill_data(refill_data), .repl_access(repl_access),
    .repl_update(repl_update), .refill_done(refill_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Scoreboard monitor: every refill write and every completion must be expected.
  always @(negedge clk) begin
    if (refill_we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_refill got way=%0d word=%0d data=%h required none",
                 refill_way, refill_word, refill_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({refill_way, refill_word, refill_data} !== mon_e) begin
          bad++;
          $display("FAIL refill_write got way=%0d word=%0d data=%h required way=%0d word=%0d data=%h",
                   refill_way, refill_word, refill_data, mon_e.way, mon_e.word, mon_e.data);
        end
      end
    end
    if (refill_done) begin
      total++;
      if (done_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done got refill_done=1 required 0");
      end else begin
        mon_a = done_q.pop_front();
        if (repl_access !== mon_a || repl_update !== 1'b1) begin
          bad++;
          $display("FAIL repl_update got access=%b update=%b required access=%b update=1",
                   repl_access, repl_update, mon_a);
        end
      end
    end else if (repl_update !== 1'b0 || repl_access !== 4'b0) begin
      total++;
      bad++;
      $display("FAIL repl_idle got access=%b update=%b required 0000/0", repl_access, repl_update);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_miss(input logic [31:0] a, input logic [3:0] sv, input logic [3:0] sd,
                            input logic [1:0] lru);
    int n = 0;
    miss_valid = 1'b1; miss_addr = a; set_valid = sv; set_dirty = sd; victim_lru = lru;
    @(negedge clk);
    while (!miss_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (miss_ready !== 1'b1) begin
      bad++;
      $display("FAIL miss_accept_timeout got miss_ready=%b required 1", miss_ready);
    end
    step();
    miss_valid = 1'b0;
    @(negedge clk);
    total++;
    if (miss_ready !== 1'b0 || rd_req !== 1'b0 || wb_req !== 1'b0) begin
      bad++;
      $display("FAIL select_cycle got ready=%b rd_req=%b wb_req=%b required 0/0/0",
               miss_ready, rd_req, wb_req);
    end
    step();
  endtask

  task automatic do_wb(input logic [1:0] way, input int delay);
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      total++;
      if (wb_req !== 1'b1 || wb_way !== way || rd_req !== 1'b0) begin
        bad++;
        $display("FAIL wb_hold got wb_req=%b wb_way=%0d rd_req=%b required 1/%0d/0",
                 wb_req, wb_way, rd_req, way);
      end
      step();
    end
    wb_done = 1'b1;
    step();
    wb_done = 1'b0;
  endtask

  task automatic do_rd_req(input logic [31:0] a, input int stall);
    for (int k = 0; k < stall; k++) begin
      rd_valid = 1'b1;
      rd_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      total++;
      if (rd_req !== 1'b1 || rd_addr !== a || refill_we !== 1'b0 || wb_req !== 1'b0) begin
        bad++;
        $display("FAIL rd_req_stall got rd_req=%b rd_addr=%h we=%b wb_req=%b required 1/%h/0/0",
                 rd_req, rd_addr, refill_we, wb_req, a);
      end
      step();
    end
    rd_valid = 1'b0;
    rd_ready = 1'b1;
    @(negedge clk);
    total++;
    if (rd_req !== 1'b1 || rd_addr !== a || wb_req !== 1'b0) begin
      bad++;
      $display("FAIL rd_req got rd_req=%b rd_addr=%h wb_req=%b required 1/%h/0",
               rd_req, rd_addr, wb_req, a);
    end
    step();
    rd_ready = 1'b0;
  endtask

  task automatic send_beats(input logic [1:0] way, input int n, input bit last_on);
    for (int k = 0; k < n; k++) begin
      if (k == 2 && n > 3) begin
        rd_valid = 1'b0;
        rd_last  = 1'b1;
        step();
      end
      rd_valid = 1'b1;
      rd_data  = $urandom;
      rd_last  = last_on && (k == n - 1);
      exp_q.push_back('{way: way, word: 3'(k % 8), data: rd_data});
      if (last_on && k == n - 1) done_q.push_back(4'b0001 << way);
      step();
    end
    rd_valid = 1'b0;
    rd_last  = 1'b0;
  endtask

  task automatic finish_done();
    @(negedge clk);
    total++;
    if (refill_done !== 1'b1 || miss_ready !== 1'b0) begin
      bad++;
      $display("FAIL done_cycle got refill_done=%b miss_ready=%b required 1/0", refill_done, miss_ready);
    end
    step();
    @(negedge clk);
    total++;
    if (refill_done !== 1'b0 || miss_ready !== 1'b1) begin
      bad++;
      $display("FAIL back_to_idle got refill_done=%b miss_ready=%b required 0/1", refill_done, miss_ready);
    end
    total++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got writes=%0d dones=%0d required 0/0", exp_q.size(), done_q.size());
    end
    step();
  endtask

  task automatic test_reset();
    resetn = 1'b1; miss_valid = 1'b0; miss_addr = '0; set_valid = '0; set_dirty = '0;
    victim_lru = '0; wb_done = 1'b0; rd_ready = 1'b0; rd_valid = 1'b0; rd_data = '0; rd_last = 1'b0;
    repeat (3) step();
    @(negedge clk);
    total++;
    if (miss_ready !== 1'b1 || wb_req !== 1'b0 || rd_req !== 1'b0 || refill_we !== 1'b0 ||
        repl_update !== 1'b0 || refill_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl got ready=%b wb=%b rd=%b we=%b upd=%b done=%b required 1/0/0/0/0/0",
               miss_ready, wb_req, rd_req, refill_we, repl_update, refill_done);
    end
    total++;
    if (repl_access !== 4'b0 || refill_way !== 2'b0 || refill_word !== 3'b0 ||
        rd_addr !== 32'b0 || wb_way !== 2'b0) begin
      bad++;
      $display("FAIL reset_data got access=%b rway=%0d rword=%0d rd_addr=%h wb_way=%0d required zeros",
               repl_access, refill_way, refill_word, rd_addr, wb_way);
    end
    step();
    resetn = 1'b0;
    wb_done = 1'b1;
    step();
    wb_done = 1'b0;
    @(negedge clk);
    total++;
    if (miss_ready !== 1'b1 || wb_req !== 1'b0) begin
      bad++;
      $display("FAIL idle_wb_done_ignored got ready=%b wb_req=%b required 1/0", miss_ready, wb_req);
    end
    step();
  endtask

  task automatic test_invalid_way();
    start_miss(32'h0000_1234, 4'b1011, 4'b0000, 2'd2);
    do_rd_req(32'h0000_1220, 0);
    send_beats(2'd2, 8, 1'b1);
    finish_done();
  endtask

  task automatic test_lowest_invalid();
    start_miss(32'h0000_5678, 4'b0110, 4'b1111, 2'd3);
    do_rd_req(32'h0000_5660, 0);
    send_beats(2'd0, 8, 1'b1);
    finish_done();
  endtask

  task automatic test_dirty_wb();
    start_miss(32'hABCD_0057, 4'b1111, 4'b0010, 2'd1);
    do_wb(2'd1, 3);
    do_rd_req(32'hABCD_0040, 0);
    send_beats(2'd1, 8, 1'b1);
    finish_done();
  endtask

  task automatic test_rd_stall();
    start_miss(32'h8000_003F, 4'b1111, 4'b0000, 2'd3);
    do_rd_req(32'h8000_0020, 5);
    send_beats(2'd3, 8, 1'b1);
    finish_done();
  endtask

  task automatic test_early_and_wrap();
    start_miss(32'h0000_0100, 4'b1111, 4'b0000, 2'd0);
    do_rd_req(32'h0000_0100, 0);
    send_beats(2'd0, 3, 1'b1);
    finish_done();
    start_miss(32'h0000_0200, 4'b1101, 4'b1111, 2'd3);
    do_rd_req(32'h0000_0200, 0);
    send_beats(2'd1, 10, 1'b1);
    finish_done();
  endtask

  task automatic test_reset_mid_refill();
    start_miss(32'h0000_0300, 4'b1111, 4'b0000, 2'd2);
    do_rd_req(32'h0000_0300, 0);
    send_beats(2'd2, 4, 1'b0);
    resetn = 1'b1;
    step();
    resetn = 1'b0;
    @(negedge clk);
    total++;
    if (miss_ready !== 1'b1 || refill_done !== 1'b0 || rd_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_refill got ready=%b done=%b rd_req=%b required 1/0/0",
               miss_ready, refill_done, rd_req);
    end
    for (int k = 0; k < 3; k++) begin
      rd_valid = 1'b1; rd_last = 1'b1; wb_done = 1'b1; rd_data = $urandom;
      @(negedge clk);
      total++;
      if (refill_we !== 1'b0 || refill_done !== 1'b0 || wb_req !== 1'b0 || miss_ready !== 1'b1) begin
        bad++;
        $display("FAIL stale_beats got we=%b done=%b wb_req=%b ready=%b required 0/0/0/1",
                 refill_we, refill_done, wb_req, miss_ready);
      end
      step();
    end
    rd_valid = 1'b0; rd_last = 1'b0; wb_done = 1'b0;
    total++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      bad++;
      $display("FAIL reset_drain got writes=%0d dones=%0d required 0/0", exp_q.size(), done_q.size());
    end
  endtask

  task automatic test_back_to_back();
    start_miss(32'h0000_0400, 4'b1111, 4'b0000, 2'd1);
    do_rd_req(32'h0000_0400, 0);
    send_beats(2'd1, 8, 1'b1);
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_0577;
    set_valid  = 4'b0111;
    @(negedge clk);
    total++;
    if (refill_done !== 1'b1 || miss_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_done got refill_done=%b miss_ready=%b required 1/0", refill_done, miss_ready);
    end
    step();
    @(negedge clk);
    total++;
    if (miss_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_idle got miss_ready=%b required 1", miss_ready);
    end
    step();
    miss_valid = 1'b0;
    @(negedge clk);
    total++;
    if (miss_ready !== 1'b0 || rd_req !== 1'b0) begin
      bad++;
      $display("FAIL b2b_select got ready=%b rd_req=%b required 0/0", miss_ready, rd_req);
    end
    step();
    do_rd_req(32'h0000_0560, 0);
    send_beats(2'd3, 8, 1'b1);
    finish_done();
  endtask

  initial begin
    test_reset();
    test_invalid_way();
    test_lowest_invalid();
    test_dirty_wb();
    test_rd_stall();
    test_early_and_wrap();
    test_reset_mid_refill();
    test_back_to_back();
    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
